branch_resolver: RTL

- Consumer side of the 32-bit magnitude comparator. Takes the comparator's one-hot equal/lower/greater flags plus a decoded branch opcode, resolves branch direction, selects the next PC and drives a multi-cycle pipeline flush on taken branches.
- Sits at the EX/MEM boundary of the MIPS core, between the comparator and the PC/fetch logic.
- Static predict-not-taken: every taken branch forces a flush.

---
 rtl/branch_resolver.sv | 80 ++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// branch_resolver: resolves branch direction from one-hot comparator flags, selects the next PC
// and holds a fixed-length pipeline flush after every taken branch (static predict-not-taken).
module branch_resolver #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        br_op,
    input  logic              equal,
    input  logic              lower,
    input  logic              greater,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [ADDR_W-1:0] target,
    output logic              out_valid,
    output logic              taken,
    output logic [ADDR_W-1:0] next_pc,
    output logic              flush,
    output logic              flag_err,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  taken_count
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    typedef enum logic {IDLE, FLUSH} state_t;
    state_t r_state, w_state_nxt;
    logic [FW-1:0] r_flush_cnt;
    logic w_accept, w_onehot, w_err, w_cond, w_taken;
    assign in_ready = r_state == IDLE;
    assign flush    = r_state == FLUSH;
    assign w_accept = in_valid && in_ready;
    assign w_onehot = {equal, lower, greater} inside {3'b100, 3'b010, 3'b001};
    assign w_err    = !w_onehot || br_op == 3'd7;
    assign w_cond   = br_op == 3'd0 ? equal :
                      br_op == 3'd1 ? !equal :
                      br_op == 3'd2 ? lower :
                      br_op == 3'd3 ? equal | greater :
                      br_op == 3'd4 ? greater :
                      br_op == 3'd5 ? equal | lower :
                      br_op == 3'd6;
    assign w_taken  = !w_err && w_cond;
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == IDLE && w_accept && w_taken)
            w_state_nxt = FLUSH;
        else if (r_state == FLUSH && r_flush_cnt == FW'(1))
            w_state_nxt = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_flush_cnt  <= '0;
            out_valid    <= 1'b0;
            taken        <= 1'b0;
            next_pc      <= '0;
            flag_err     <= 1'b0;
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            out_valid <= w_accept;
            if (r_state == FLUSH)
                r_flush_cnt <= r_flush_cnt - FW'(1);
            if (w_accept) begin
                taken    <= w_taken;
                next_pc  <= w_taken ? target : pc_plus4;
                flag_err <= w_err;
                if (w_taken)
                    r_flush_cnt <= FW'(FLUSH_CYCLES);
                // counters saturate rather than wrap
                if (!w_err && branch_count != '1)
                    branch_count <= branch_count + CNT_W'(1);
                if (w_taken && taken_count != '1)
                    taken_count <= taken_count + CNT_W'(1);
            end
        end
    end
endmodule
